// File: rtl/rf_write_port_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_port_arbiter
//   Owns the single register-file write port and shares it between the
//   pipeline write-back stage and the debug unit. Write-back has priority;
//   a debug request blocked for MAX_WAIT consecutive cycles forces a
//   one-cycle pipeline stall so that the debug write can proceed.
//   Register-file outputs are registered: one cycle from acceptance to write.
//
// Ports
//   i_clk, i_reset           clock (rising edge), async active-high reset
//   i_wb_we/addr/data        write-back stage write request (addr resolved)
//   i_dbg_valid/addr/data    debug write request, held stable until accepted
//   o_dbg_ready              combinational grant for the debug request
//   o_stall_pipe             freezes PC and all pipeline regs incl. MEM/WB
//   o_rf_we/addr/data        registered register-file write port
//
// MAX_WAIT must be >= 1.
// ---------------------------------------------------------------------------
module rf_write_port_arbiter #(
    parameter int unsigned NB_DATA        = 32,
    parameter int unsigned NB_REG_ADDRESS = 5,
    parameter int unsigned MAX_WAIT       = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wb_we,
    input  logic [NB_REG_ADDRESS-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0]        i_wb_data,
    input  logic                      i_dbg_valid,
    input  logic [NB_REG_ADDRESS-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0]        i_dbg_data,
    output logic                      o_dbg_ready,
    output logic                      o_stall_pipe,
    output logic                      o_rf_we,
    output logic [NB_REG_ADDRESS-1:0] o_rf_addr,
    output logic [NB_DATA-1:0]        o_rf_data
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      rf_we_q, rf_we_d;
    logic [NB_REG_ADDRESS-1:0] rf_addr_q, rf_addr_d;
    logic [NB_DATA-1:0]        rf_data_q, rf_data_d;

    logic                      wb_active;
    logic                      dbg_ready;
    logic                      dbg_accept;

    // Writes to r0 are architecturally discarded, so they never occupy the port.
    assign wb_active  = i_wb_we & (i_wb_addr != '0);
    assign dbg_accept = i_dbg_valid & dbg_ready;

    // Next-state / grant logic for the starvation guard.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dbg_ready = 1'b0;
        cnt_inc   = cnt_q + CNT_ONE;

        case (state_q)
            ST_IDLE: begin
                dbg_ready = i_dbg_valid & ~wb_active;
                if (i_dbg_valid & wb_active) begin
                    cnt_d   = CNT_ONE;
                    state_d = (MAX_WAIT == 1) ? ST_FORCE : ST_WAIT;
                end
            end

            ST_WAIT: begin
                dbg_ready = i_dbg_valid & ~wb_active;
                // Accepted or withdrawn: either way the wait is over.
                if (!i_dbg_valid || !wb_active) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_MAX) ? ST_FORCE : ST_WAIT;
                end
            end

            ST_FORCE: begin
                // Debug wins unconditionally; the stalled write-back re-presents.
                dbg_ready = i_dbg_valid;
                state_d   = ST_IDLE;
                cnt_d     = '0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-port source selection; address/data hold when the port is idle.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;

        if (dbg_accept) begin
            // A debug write to r0 still completes its handshake but writes nothing.
            rf_we_d   = (i_dbg_addr != '0);
            rf_addr_d = i_dbg_addr;
            rf_data_d = i_dbg_data;
        end else if (wb_active) begin
            rf_we_d   = 1'b1;
            rf_addr_d = i_wb_addr;
            rf_data_d = i_wb_data;
        end
    end

    // State and write-port registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign o_dbg_ready  = dbg_ready;
    assign o_stall_pipe = (state_q == ST_FORCE);
    assign o_rf_we      = rf_we_q;
    assign o_rf_addr    = rf_addr_q;
    assign o_rf_data    = rf_data_q;

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_port_arbiter
//   Directed scenarios followed by randomized traffic, checked against a
//   cycle-level reference model that tracks how long the current debug
//   request has been blocked.
// ---------------------------------------------------------------------------
module tb_rf_write_port_arbiter;

    localparam int unsigned NB_DATA        = 32;
    localparam int unsigned NB_REG_ADDRESS = 5;
    localparam int unsigned MAX_WAIT       = 4;

    logic                      i_clk = 1'b0;
    logic                      i_reset = 1'b0;
    logic                      i_wb_we = 1'b0;
    logic [NB_REG_ADDRESS-1:0] i_wb_addr = '0;
    logic [NB_DATA-1:0]        i_wb_data = '0;
    logic                      i_dbg_valid = 1'b0;
    logic [NB_REG_ADDRESS-1:0] i_dbg_addr = '0;
    logic [NB_DATA-1:0]        i_dbg_data = '0;
    logic                      o_dbg_ready;
    logic                      o_stall_pipe;
    logic                      o_rf_we;
    logic [NB_REG_ADDRESS-1:0] o_rf_addr;
    logic [NB_DATA-1:0]        o_rf_data;

    rf_write_port_arbiter #(
        .NB_DATA        (NB_DATA),
        .NB_REG_ADDRESS (NB_REG_ADDRESS),
        .MAX_WAIT       (MAX_WAIT)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .i_dbg_valid  (i_dbg_valid),
        .i_dbg_addr   (i_dbg_addr),
        .i_dbg_data   (i_dbg_data),
        .o_dbg_ready  (o_dbg_ready),
        .o_stall_pipe (o_stall_pipe),
        .o_rf_we      (o_rf_we),
        .o_rf_addr    (o_rf_addr),
        .o_rf_data    (o_rf_data)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: blocked-cycle count of the current debug request and
    // the write the port is expected to show after the next edge.
    int                        waited = 0;
    logic                      m_we = 1'b0;
    logic [NB_REG_ADDRESS-1:0] m_addr = '0;
    logic [NB_DATA-1:0]        m_data = '0;
    logic                      m_last_stall = 1'b0;
    logic                      m_last_ready = 1'b0;

    logic                      obs_ready;
    logic                      obs_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check grant/stall mid
    // cycle, then check the registered write just after the rising edge.
    task automatic run_cycle(input logic wwe, input logic [NB_REG_ADDRESS-1:0] wa,
                             input logic [NB_DATA-1:0] wd, input logic dv,
                             input logic [NB_REG_ADDRESS-1:0] da,
                             input logic [NB_DATA-1:0] dd);
        bit wb_act;
        bit stall_e;
        bit ready_e;
        @(negedge i_clk);
        i_wb_we     = wwe;
        i_wb_addr   = wa;
        i_wb_data   = wd;
        i_dbg_valid = dv;
        i_dbg_addr  = da;
        i_dbg_data  = dd;
        #1;
        wb_act  = wwe && (wa != 0);
        stall_e = (waited == int'(MAX_WAIT));
        ready_e = dv && (stall_e || !wb_act);
        obs_ready = o_dbg_ready;
        obs_stall = o_stall_pipe;
        check("dbg_ready", 64'(o_dbg_ready), 64'(ready_e));
        check("stall_pipe", 64'(o_stall_pipe), 64'(stall_e));
        if (ready_e) begin
            m_we   = (da != 0);
            m_addr = da;
            m_data = dd;
        end else if (wb_act) begin
            m_we   = 1'b1;
            m_addr = wa;
            m_data = wd;
        end else begin
            m_we = 1'b0;
        end
        if (stall_e || !dv || ready_e) waited = 0;
        else waited++;
        m_last_stall = stall_e;
        m_last_ready = ready_e;
        @(posedge i_clk);
        #1;
        check("rf_we", 64'(o_rf_we), 64'(m_we));
        check("rf_addr", 64'(o_rf_addr), 64'(m_addr));
        check("rf_data", 64'(o_rf_data), 64'(m_data));
    endtask

    // Reset raised mid-cycle; outputs must clear before any clock edge.
    task automatic async_reset();
        @(negedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("rst_rf_we", 64'(o_rf_we), 64'(0));
        check("rst_rf_addr", 64'(o_rf_addr), 64'(0));
        check("rst_rf_data", 64'(o_rf_data), 64'(0));
        check("rst_stall", 64'(o_stall_pipe), 64'(0));
        waited       = 0;
        m_we         = 1'b0;
        m_addr       = '0;
        m_data       = '0;
        m_last_stall = 1'b0;
        m_last_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        logic                      wwe;
        logic [NB_REG_ADDRESS-1:0] wa;
        logic [NB_DATA-1:0]        wd;
        logic                      dv;
        logic [NB_REG_ADDRESS-1:0] da;
        logic [NB_DATA-1:0]        dd;

        // Reset with a write-back in flight.
        i_wb_we   = 1'b1;
        i_wb_addr = 5'd7;
        i_wb_data = 32'h1111_2222;
        async_reset();

        // Plain write-back, then a write-back to r0.
        run_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        check("t2_we", 64'(o_rf_we), 64'(1));
        check("t2_addr", 64'(o_rf_addr), 64'(5));
        check("t2_data", 64'(o_rf_data), 64'hDEAD_BEEF);
        run_cycle(1'b1, 5'd0, 32'h0BAD_0BAD, 1'b0, 5'd0, 32'h0);
        check("t2_r0_we", 64'(o_rf_we), 64'(0));

        // Debug write with write-back idle.
        run_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0000_1234);
        check("t3_ready", 64'(obs_ready), 64'(1));
        check("t3_we", 64'(o_rf_we), 64'(1));
        check("t3_addr", 64'(o_rf_addr), 64'(3));
        check("t3_data", 64'(o_rf_data), 64'h0000_1234);

        // Debug to r0, then a JAL write-back to r31.
        run_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5555_5555);
        check("t5_ready", 64'(obs_ready), 64'(1));
        check("t5_we", 64'(o_rf_we), 64'(0));
        run_cycle(1'b1, 5'd31, 32'h0000_ABCD, 1'b0, 5'd0, 32'h0);
        check("t5_jal_we", 64'(o_rf_we), 64'(1));
        check("t5_jal_addr", 64'(o_rf_addr), 64'(31));

        // Starved debug request forced through after MAX_WAIT cycles.
        for (int c = 0; c <= 6; c++) begin
            logic [NB_DATA-1:0] wbd;
            wbd = (c <= 4) ? 32'h100 + 32'(c) : 32'h104;
            run_cycle(1'b1, 5'd8, wbd, (c <= 4), 5'd9, 32'h0000_CAFE);
            if (c < 4) begin
                check("t4_ready_blk", 64'(obs_ready), 64'(0));
                check("t4_stall_blk", 64'(obs_stall), 64'(0));
                check("t4_wb_addr", 64'(o_rf_addr), 64'(8));
                check("t4_wb_data", 64'(o_rf_data), 64'(32'h100 + 32'(c)));
            end else if (c == 4) begin
                check("t4_stall", 64'(obs_stall), 64'(1));
                check("t4_ready", 64'(obs_ready), 64'(1));
                check("t4_dbg_addr", 64'(o_rf_addr), 64'(9));
                check("t4_dbg_data", 64'(o_rf_data), 64'h0000_CAFE);
            end else begin
                check("t4_stall_off", 64'(obs_stall), 64'(0));
                check("t4_held_addr", 64'(o_rf_addr), 64'(8));
                check("t4_held_data", 64'(o_rf_data), 64'h104);
            end
        end

        // Reset while waiting: blocking count restarts from zero.
        run_cycle(1'b1, 5'd8, 32'h200, 1'b1, 5'd10, 32'h0000_BEEF);
        run_cycle(1'b1, 5'd8, 32'h201, 1'b1, 5'd10, 32'h0000_BEEF);
        async_reset();
        for (int c = 0; c <= 4; c++) begin
            run_cycle(1'b1, 5'd8, 32'h300 + 32'(c), 1'b1, 5'd10, 32'h0000_BEEF);
            check("t6_stall", 64'(obs_stall), 64'(c == 4));
            check("t6_ready", 64'(obs_ready), 64'(c == 4));
        end
        run_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Randomized traffic honouring both sides' hold rules.
        wwe = 1'b0; wa = '0; wd = '0;
        dv = 1'b0; da = '0; dd = '0;
        for (int n = 0; n < 800; n++) begin
            if (!m_last_stall) begin
                wwe = ($urandom_range(0, 3) != 0);
                wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wd  = $urandom;
            end
            if (dv && !m_last_ready) begin
                if ($urandom_range(0, 19) == 0) dv = 1'b0;
            end else begin
                dv = ($urandom_range(0, 2) == 0);
                da = 5'($urandom_range(0, 31));
                dd = $urandom;
            end
            if ($urandom_range(0, 199) == 0) async_reset();
            run_cycle(wwe, wa, wd, dv, da, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_port_arbiter.md
Name: rf_write_port_arbiter

Overview:
- Owns the single register-file write port. Shares it between the pipeline write-back stage and the debug unit's register-write requests.
- The pipeline has priority. A debug request that is blocked for MAX_WAIT cycles forces a one-cycle pipeline stall so that the debug write can proceed.
- Outputs to the register file are registered: one-cycle latency from an accepted request to the register-file write.

Parameters:
NB_DATA, 32, register data width
NB_REG_ADDRESS, 5, register address width
MAX_WAIT, 4, blocked debug cycles tolerated before forcing a stall (legal range >= 1)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  reset; asynchronous, active-high
i_wb_we  in  1  write-back stage write enable
i_wb_addr  in  NB_REG_ADDRESS  write-back destination; already resolved, so JAL's r31 arrives here
i_wb_data  in  NB_DATA  write-back data
i_dbg_valid  in  1  debug write request; held with addr and data stable until accepted
i_dbg_addr  in  NB_REG_ADDRESS  debug destination register
i_dbg_data  in  NB_DATA  debug write data
o_dbg_ready  out  1  combinational grant; a transfer occurs on the edge where i_dbg_valid and o_dbg_ready are both 1
o_stall_pipe  out  1  freezes the PC and all pipeline registers, including MEM/WB
o_rf_we  out  1  register-file write enable (registered)
o_rf_addr  out  NB_REG_ADDRESS  register-file write address (registered)
o_rf_data  out  NB_DATA  register-file write data (registered)

Behaviour:
Reset and definitions
- Reset: state=IDLE, cnt=0. o_rf_we, o_rf_addr and o_rf_data are 0. o_stall_pipe=0.
- wb_active = i_wb_we & (i_wb_addr != 0).
- cnt is sized $clog2(MAX_WAIT+1) bits and counts consecutive blocked debug cycles.

States (Moore o_stall_pipe = state==FORCE)
- IDLE:
  - o_dbg_ready = i_dbg_valid & !wb_active.
  - If i_dbg_valid & wb_active: cnt<=1; go to FORCE if MAX_WAIT==1, else WAIT.
- WAIT:
  - o_dbg_ready = i_dbg_valid & !wb_active.
  - If accepted: IDLE, cnt<=0.
  - If i_dbg_valid drops: IDLE, cnt<=0.
  - If still blocked: cnt<=cnt+1; go to FORCE when cnt+1==MAX_WAIT.
- FORCE:
  - o_dbg_ready = i_dbg_valid. The debug write wins even when wb_active.
  - The concurrent write-back write is not performed. Because the stall holds MEM/WB, the same write re-presents next cycle and nothing is lost.
  - Exit to IDLE with cnt<=0, whether or not the request was accepted or i_dbg_valid dropped.

Write selection, registered each edge
- Debug accepted: o_rf_we<=(i_dbg_addr!=0), o_rf_addr<=i_dbg_addr, o_rf_data<=i_dbg_data.
- Otherwise, if wb_active: o_rf_we<=1, o_rf_addr<=i_wb_addr, o_rf_data<=i_wb_data.
- Otherwise: o_rf_we<=0; addr and data hold their previous values.
- Writes to r0 are never issued. A debug write to r0 is still accepted, with o_dbg_ready=1, so the handshake completes.

Guarantees and edge cases
- Latency: an accepted request appears on o_rf_* on the next cycle.
- Worst-case debug grant is cycle MAX_WAIT, counting the first valid cycle as 0.
- o_stall_pipe is high for exactly one cycle per forced grant.
- Back-to-back debug requests under continuous write-back each restart cnt from 0.
- The debug requester must not change addr/data while valid & !ready. Dropping valid early returns the block to IDLE with no write.
- Reset mid-operation: immediate return to IDLE. No stall and no pending write. An un-accepted debug request stays pending on the requester side.

Test Plan:
1. Reset asserted mid-cycle with i_wb_we=1 -> o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_stall_pipe=0 immediately, without waiting for a clock edge.
2. wb_we=1, addr=5, data=0xDEADBEEF, no debug -> next cycle o_rf_we=1, addr=5, data=0xDEADBEEF. Then wb_we=1, addr=0 -> o_rf_we=0.
3. Debug valid, addr=3, data=0x00001234, wb idle -> o_dbg_ready=1 the same cycle. Next cycle o_rf_we=1, addr=3, data=0x00001234.
4. MAX_WAIT=4, continuous wb writes to r8 with data changing per cycle; debug valid at cycle 0, addr=9, data=0xCAFE:
   - cycles 0-3: ready=0, r8 written each cycle.
   - cycle 4: stall=1, ready=1, wb data held.
   - cycle 5: o_rf = r9/0xCAFE, stall=0.
   - cycle 6: o_rf = the held r8 write.
5. Debug to r0 while wb idle -> ready=1, no o_rf_we. Simultaneously wb addr=31 (JAL) next cycle -> o_rf_we=1, addr=31.
6. Reset asserted in WAIT with cnt=2, wb and debug still active -> after release, debug is blocked a full 4 cycles before FORCE (cnt cleared).
